gf180mcu_fd_sc_mcu9t5v0__bufz_arb_seq: RTL and testbench

- Parametrised, clocked successor to the single tristate buffer cell: NCH request channels share one WIDTH-bit tristate bus output.
- Channels are granted in round-robin order, and the granted channel's data is registered before being driven.
- A programmable number of dead (high-Z) cycles is inserted between bus owners, so two drivers never overlap.
- Used as a bus-turnaround driver for shared pad/IO buses in MCU-level designs.

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__bufz_arb_seq.sv | 173 +++++++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__bufz_arb_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bufz_arb_seq.sv
// Round-robin arbitrated tristate bus driver.
// NCH request channels share one WIDTH-bit tristate output. The granted
// channel's data is registered before being driven. DEAD high-Z cycles are
// inserted between owners so two drivers never overlap on the pad bus.
// An optional MAXHOLD limit forces the owner off the bus when another
// channel is waiting.
module gf180mcu_fd_sc_mcu9t5v0__bufz_arb_seq #(
    parameter int WIDTH   = 8,
    parameter int NCH     = 4,
    parameter int DEAD    = 1,
    parameter int MAXHOLD = 0
) (
    input  logic                   CLK,
    input  logic                   RN,
    input  logic                   EN,
    input  logic [NCH-1:0]         REQ,
    input  logic [NCH*WIDTH-1:0]   I,
    output logic [NCH-1:0]         GNT,
    output logic                   BUSY,
    output logic [WIDTH-1:0]       Z,
    inout  wire                    VDD,
    inout  wire                    VSS
);

    localparam int IDXW = $clog2(NCH);
    localparam logic [2:0] DEAD_C    = 3'(DEAD);
    localparam logic [7:0] MAXHOLD_C = 8'(MAXHOLD);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    // Supply pins carry no logic; kept only so the cell pinout matches.
    wire unused_supply_s = VDD ^ VSS;

    state_t               state_r, state_n;
    logic [NCH-1:0]       gnt_r, gnt_n;
    logic                 busy_r;
    logic [WIDTH-1:0]     data_r, data_n;
    logic [IDXW-1:0]      last_r, last_n;
    logic [7:0]           hold_r, hold_n;
    logic [2:0]           dead_r, dead_n;

    logic [WIDTH-1:0]     ch_data_s [NCH];
    logic [IDXW:0]        pick_s;
    logic [IDXW-1:0]      pick_idx_s;
    logic                 own_req_s;
    logic                 others_s;
    logic                 force_rel_s;
    logic                 arb_en_s;

    // Round-robin search: first requester strictly after 'last', wrapping.
    // Scanned from the farthest candidate to the nearest so the nearest wins.
    // Result MSB flags that a requester was found.
    function automatic logic [IDXW:0] rr_pick(input logic [NCH-1:0] req,
                                              input logic [IDXW-1:0] last);
        logic [IDXW:0]   res;
        logic [IDXW-1:0] idx;
        res = {(IDXW+1){1'b0}};
        for (int j = NCH; j >= 1; j--) begin
            idx = IDXW'((int'(last) + j) % NCH);
            if (req[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Split the packed channel bus into per-channel words.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            ch_data_s[k] = I[k*WIDTH +: WIDTH];
        end
    end

    // Arbitration candidate and release conditions for the current owner.
    always_comb begin
        pick_s      = rr_pick(REQ, last_r);
        pick_idx_s  = pick_s[IDXW-1:0];
        own_req_s   = REQ[last_r];
        others_s    = |(REQ & ~gnt_r);
        force_rel_s = (MAXHOLD_C != 8'd0) && (hold_r == MAXHOLD_C) && others_s;
    end

    // Next-state logic: IDLE arbitrates, DRIVE tracks/releases, TURN counts dead cycles.
    always_comb begin
        state_n  = state_r;
        gnt_n    = gnt_r;
        data_n   = data_r;
        last_n   = last_r;
        hold_n   = hold_r;
        dead_n   = dead_r;
        arb_en_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                arb_en_s = 1'b1;
            end
            ST_DRIVE: begin
                if (own_req_s && !force_rel_s) begin
                    data_n = ch_data_s[last_r];
                    hold_n = (hold_r == 8'hFF) ? hold_r : hold_r + 8'd1;
                end else begin
                    gnt_n  = {NCH{1'b0}};
                    hold_n = 8'd0;
                    if (DEAD_C != 3'd0) begin
                        state_n = ST_TURN;
                        dead_n  = DEAD_C;
                    end else begin
                        // Zero turnaround: hand over at this very edge; the
                        // released owner is last in line because last_r == owner.
                        state_n  = ST_IDLE;
                        arb_en_s = 1'b1;
                    end
                end
            end
            ST_TURN: begin
                if (dead_r <= 3'd1) begin
                    dead_n   = 3'd0;
                    state_n  = ST_IDLE;
                    arb_en_s = 1'b1;
                end else begin
                    dead_n = dead_r - 3'd1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                gnt_n   = {NCH{1'b0}};
                hold_n  = 8'd0;
                dead_n  = 3'd0;
            end
        endcase
        if (arb_en_s && pick_s[IDXW]) begin
            state_n = ST_DRIVE;
            gnt_n   = {{(NCH-1){1'b0}}, 1'b1} << pick_idx_s;
            data_n  = ch_data_s[pick_idx_s];
            last_n  = pick_idx_s;
            hold_n  = 8'd1;
        end else begin
            hold_n = hold_n;
        end
    end

    // State and datapath registers; async reset gives channel 0 first priority.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_r <= ST_IDLE;
            gnt_r   <= {NCH{1'b0}};
            busy_r  <= 1'b0;
            data_r  <= {WIDTH{1'b0}};
            last_r  <= IDXW'(NCH - 1);
            hold_r  <= 8'd0;
            dead_r  <= 3'd0;
        end else begin
            state_r <= state_n;
            gnt_r   <= gnt_n;
            busy_r  <= |gnt_n;
            data_r  <= data_n;
            last_r  <= last_n;
            hold_r  <= hold_n;
            dead_r  <= dead_n;
        end
    end

    assign GNT  = gnt_r;
    assign BUSY = busy_r;
    // Whole-bus enable: the bus is either fully driven or fully released.
    assign Z    = (busy_r & EN) ? data_r : {WIDTH{1'bz}};

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__bufz_arb_seq.sv
// Bench for the arbitrated tristate bus driver. Two instances share stimulus:
// u_d1 (DEAD=1, MAXHOLD=4) and u_d0 (DEAD=0, unlimited hold). A cycle-level
// reference model built from owner/gap counters predicts GNT, BUSY and Z.
module tb_gf180mcu_fd_sc_mcu9t5v0__bufz_arb_seq;

    localparam int W = 8;
    localparam int N = 4;

    logic            clk;
    logic            rn;
    logic            en;
    logic [N-1:0]    req;
    logic [W-1:0]    i_arr [N];
    wire  [N*W-1:0]  i_bus = {i_arr[3], i_arr[2], i_arr[1], i_arr[0]};
    wire  [N-1:0]    g0_w, g1_w;
    wire             b0_w, b1_w;
    wire  [W-1:0]    z0_w, z1_w;
    wire             vdd_w = 1'b1;
    wire             vss_w = 1'b0;

    int nvec  = 0;
    int nfail = 0;

    // model state per instance: 0 -> u_d1, 1 -> u_d0
    int         own   [2];
    int         gap   [2];
    int         hold  [2];
    int         last  [2];
    logic [7:0] mdata [2];
    int         dead_p[2] = '{1, 0};
    int         mh_p  [2] = '{4, 0};

    gf180mcu_fd_sc_mcu9t5v0__bufz_arb_seq #(.WIDTH(W), .NCH(N), .DEAD(1), .MAXHOLD(4)) u_d1 (
        .CLK(clk), .RN(rn), .EN(en), .REQ(req), .I(i_bus),
        .GNT(g0_w), .BUSY(b0_w), .Z(z0_w), .VDD(vdd_w), .VSS(vss_w));

    gf180mcu_fd_sc_mcu9t5v0__bufz_arb_seq #(.WIDTH(W), .NCH(N), .DEAD(0), .MAXHOLD(0)) u_d0 (
        .CLK(clk), .RN(rn), .EN(en), .REQ(req), .I(i_bus),
        .GNT(g1_w), .BUSY(b1_w), .Z(z1_w), .VDD(vdd_w), .VSS(vss_w));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            own[m] = -1; gap[m] = 0; hold[m] = 0; last[m] = N - 1; mdata[m] = 8'h00;
        end
    endtask

    task automatic try_grant(input int m);
        for (int j = 1; j <= N; j++) begin
            int c;
            c = (last[m] + j) % N;
            if (req[c] && own[m] < 0) begin
                own[m] = c; last[m] = c; hold[m] = 1; mdata[m] = i_arr[c];
            end
        end
    endtask

    // One clock edge of the reference behaviour, using the inputs seen before it.
    task automatic model_edge(input int m);
        if (own[m] >= 0) begin
            bit others, forced;
            others = (req & ~(4'b0001 << own[m])) != 4'b0000;
            forced = (mh_p[m] != 0) && (hold[m] == mh_p[m]) && others;
            if (req[own[m]] && !forced) begin
                mdata[m] = i_arr[own[m]];
                hold[m]  = (hold[m] >= 255) ? 255 : hold[m] + 1;
            end else begin
                last[m] = own[m]; own[m] = -1; hold[m] = 0;
                if (dead_p[m] > 0) gap[m] = dead_p[m];
                else try_grant(m);
            end
        end else if (gap[m] > 0) begin
            gap[m]--;
            if (gap[m] == 0) try_grant(m);
        end else begin
            try_grant(m);
        end
    endtask

    function automatic logic [3:0] exp_gnt(input int m);
        return (own[m] >= 0) ? (4'b0001 << own[m]) : 4'b0000;
    endfunction

    function automatic logic [7:0] exp_z(input int m);
        logic [7:0] zz;
        zz = {8{1'bz}};
        return (own[m] >= 0 && en) ? mdata[m] : zz;
    endfunction

    task automatic check_all(input string ph);
        chk({ph, ".gnt_d1"},  {28'd0, g0_w}, {28'd0, exp_gnt(0)});
        chk({ph, ".busy_d1"}, {31'd0, b0_w}, {31'd0, (own[0] >= 0)});
        chk({ph, ".z_d1"},    {24'd0, z0_w}, {24'd0, exp_z(0)});
        chk({ph, ".gnt_d0"},  {28'd0, g1_w}, {28'd0, exp_gnt(1)});
        chk({ph, ".busy_d0"}, {31'd0, b1_w}, {31'd0, (own[1] >= 0)});
        chk({ph, ".z_d0"},    {24'd0, z1_w}, {24'd0, exp_z(1)});
    endtask

    task automatic step(input string ph);
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_all(ph);
    endtask

    initial begin
        rn = 1'b0; en = 1'b1; req = 4'b1111;
        i_arr[0] = 8'hA5; i_arr[1] = 8'h5A; i_arr[2] = 8'h11; i_arr[3] = 8'h3C;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset_gnt_const", {28'd0, g0_w}, 32'd0);

        // first edge after reset release: channel 0 wins
        rn = 1'b1;
        step("first");
        chk("first_gnt_const", {28'd0, g0_w}, 32'h1);
        chk("first_z_const",   {24'd0, z0_w}, 32'hA5);
        req = 4'b0000;
        repeat (3) step("idle");

        // round robin with one dead cycle
        req = 4'b1010;
        repeat (3) step("rr_hold");
        req = 4'b1000;
        repeat (4) step("rr_own3");
        req = 4'b0010;
        repeat (4) step("rr_own1");
        req = 4'b0000;
        repeat (3) step("rr_idle");

        // data tracking on channel 2, channel 0 carries X
        i_arr[0] = 8'bx;
        req = 4'b0100;
        for (int k = 1; k <= 6; k++) begin
            i_arr[2] = 8'(k);
            step("track");
        end
        req = 4'b0000;
        repeat (3) step("track_idle");
        i_arr[0] = 8'hA5;

        // continuous two-channel demand: MAXHOLD rotation on u_d1
        req = 4'b0011;
        repeat (22) step("maxhold");
        req = 4'b0000;
        repeat (3) step("mh_idle");

        // zero-gap handover on u_d0
        req = 4'b0001;
        repeat (2) step("h0");
        req = 4'b0100;
        repeat (3) step("handover");

        // EN gating while granted, then async reset between edges
        en = 1'b0;
        repeat (2) step("en_off");
        en = 1'b1;
        step("en_on");
        #2;
        rn = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        rn = 1'b1;
        req = 4'b1111;
        step("post_rst");
        chk("post_rst_gnt_const", {28'd0, g1_w}, 32'h1);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            for (int k = 0; k < N; k++) i_arr[k] = 8'($urandom);
            en = ($urandom_range(0, 7) != 0);
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
